// File: rtl/twin_stick_mapper.sv
// Per-player twin-stick conditioner: joystick words plus two analog sticks become
// registered run/aim vectors, trigger, start and coin, with aim hold-over and auto-fire.
module twin_stick_mapper #(
    parameter int PLAYERS    = 2,
    parameter int DEADZONE   = 20,
    parameter int HOLD_TICKS = 4,
    parameter int AF_PERIOD  = 3,
    parameter int SOCD       = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  cfg_rotate,
    input  logic                  cfg_aimfire,
    input  logic                  cfg_autofire,
    input  logic [PLAYERS*32-1:0] joy_digital,
    input  logic [PLAYERS*16-1:0] analog_l,
    input  logic [PLAYERS*16-1:0] analog_r,
    output logic [PLAYERS*4-1:0]  btn_run,
    output logic [PLAYERS*4-1:0]  btn_aim,
    output logic [PLAYERS-1:0]    btn_trigger,
    output logic [PLAYERS-1:0]    btn_start,
    output logic                  btn_coin
);

    localparam int HW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [7:0] AF_LOAD = 8'(AF_PERIOD);
    localparam logic signed [8:0] DZ_POS = $signed(9'(DEADZONE));
    localparam logic signed [8:0] DZ_NEG = -DZ_POS;

    // Sticks are sign-extended to 9 bits so -128 and the full deadzone range compare cleanly.
    function automatic logic [3:0] stick_dirs(input logic [15:0] stick, input logic rotate);
        logic signed [8:0] x;
        logic signed [8:0] y;
        logic up;
        logic dn;
        logic lf;
        logic rt;
        x  = {stick[7], stick[7:0]};
        y  = {stick[15], stick[15:8]};
        up = y < DZ_NEG;
        dn = y > DZ_POS;
        lf = x < DZ_NEG;
        rt = x > DZ_POS;
        if (rotate) begin
            stick_dirs = {dn & lf, dn & rt, up & lf, up & rt};
        end else begin
            stick_dirs = {dn, rt, lf, up};
        end
    endfunction

    function automatic logic [3:0] socd_clean(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (SOCD != 0) begin
            if (v[0] && v[3]) begin
                r[0] = 1'b0;
                r[3] = 1'b0;
            end
            if (v[1] && v[2]) begin
                r[1] = 1'b0;
                r[2] = 1'b0;
            end
        end
        return r;
    endfunction

    logic unused_joy;
    assign unused_joy = ^joy_digital;

    logic coin_d;
    logic coin_q;

    always_comb begin
        coin_d = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            coin_d = coin_d | joy_digital[32*p+6];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_q <= 1'b0;
        end else begin
            coin_q <= coin_d;
        end
    end

    assign btn_coin = coin_q;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [3:0]    run_dig;
        logic [3:0]    aim_dig;
        logic [3:0]    aim_m;
        logic          src;
        logic [3:0]    run_d,   run_q;
        logic [3:0]    aim_d,   aim_q;
        logic [HW-1:0] hold_d,  hold_q;
        logic [7:0]    af_d,    af_q;
        logic          phase_d, phase_q;
        logic          trig_d,  trig_q;
        logic          src_d,   src_q;
        logic          start_d, start_q;

        assign run_dig = {joy_digital[32*p+2], joy_digital[32*p+0],
                          joy_digital[32*p+1], joy_digital[32*p+3]};
        assign aim_dig = {joy_digital[32*p+8],  joy_digital[32*p+10],
                          joy_digital[32*p+9],  joy_digital[32*p+7]};

        always_comb begin
            run_d   = socd_clean(stick_dirs(analog_l[16*p +: 16], cfg_rotate) | run_dig);
            aim_m   = socd_clean(stick_dirs(analog_r[16*p +: 16], cfg_rotate) | aim_dig);
            start_d = joy_digital[32*p+5];

            // A fresh aim always wins over a pending ce; otherwise hold until the count expires.
            aim_d  = aim_q;
            hold_d = hold_q;
            if (aim_m != 4'd0) begin
                aim_d  = aim_m;
                hold_d = HOLD_LOAD;
            end else if (HOLD_TICKS == 0 || hold_q == '0) begin
                aim_d = 4'd0;
            end else if (ce) begin
                hold_d = hold_q - HW'(1);
                if (hold_q == HW'(1)) begin
                    aim_d = 4'd0;
                end
            end

            src     = cfg_aimfire ? (aim_m != 4'd0) : joy_digital[32*p+4];
            src_d   = src;
            trig_d  = trig_q;
            phase_d = phase_q;
            af_d    = af_q;
            if (!src) begin
                trig_d  = 1'b0;
                phase_d = 1'b1;
            end else if (!cfg_autofire) begin
                trig_d = 1'b1;
            end else if (!src_q) begin
                trig_d  = 1'b1;
                phase_d = 1'b1;
                af_d    = AF_LOAD;
            end else begin
                if (ce) begin
                    if (af_q <= 8'd1) begin
                        phase_d = ~phase_q;
                        af_d    = AF_LOAD;
                    end else begin
                        af_d = af_q - 8'd1;
                    end
                end
                trig_d = phase_d;
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                run_q   <= 4'd0;
                aim_q   <= 4'd0;
                hold_q  <= '0;
                af_q    <= 8'd0;
                phase_q <= 1'b1;
                trig_q  <= 1'b0;
                src_q   <= 1'b0;
                start_q <= 1'b0;
            end else begin
                run_q   <= run_d;
                aim_q   <= aim_d;
                hold_q  <= hold_d;
                af_q    <= af_d;
                phase_q <= phase_d;
                trig_q  <= trig_d;
                src_q   <= src_d;
                start_q <= start_d;
            end
        end

        assign btn_run[4*p +: 4] = run_q;
        assign btn_aim[4*p +: 4] = aim_q;
        assign btn_trigger[p]    = trig_q;
        assign btn_start[p]      = start_q;
    end

endmodule

// File: tb/tb_twin_stick_mapper.sv
// Bench for twin_stick_mapper: directed scenarios plus randomized segments, every clock
// compared against a counting reference model of the run/aim/hold/auto-fire rules.
module tb_twin_stick_mapper;

    localparam int PLAYERS    = 2;
    localparam int DEADZONE   = 20;
    localparam int HOLD_TICKS = 4;
    localparam int AF_PERIOD  = 3;
    localparam int SOCD       = 1;

    logic                  clk_sys = 1'b0;
    logic                  reset_n;
    logic                  ce;
    logic                  cfg_rotate;
    logic                  cfg_aimfire;
    logic                  cfg_autofire;
    logic [PLAYERS*32-1:0] joy_digital;
    logic [PLAYERS*16-1:0] analog_l;
    logic [PLAYERS*16-1:0] analog_r;
    logic [PLAYERS*4-1:0]  btn_run;
    logic [PLAYERS*4-1:0]  btn_aim;
    logic [PLAYERS-1:0]    btn_trigger;
    logic [PLAYERS-1:0]    btn_start;
    logic                  btn_coin;

    twin_stick_mapper #(
        .PLAYERS(PLAYERS), .DEADZONE(DEADZONE), .HOLD_TICKS(HOLD_TICKS),
        .AF_PERIOD(AF_PERIOD), .SOCD(SOCD)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce),
        .cfg_rotate(cfg_rotate), .cfg_aimfire(cfg_aimfire), .cfg_autofire(cfg_autofire),
        .joy_digital(joy_digital), .analog_l(analog_l), .analog_r(analog_r),
        .btn_run(btn_run), .btn_aim(btn_aim), .btn_trigger(btn_trigger),
        .btn_start(btn_start), .btn_coin(btn_coin)
    );

    always #5 clk_sys = ~clk_sys;

    int checkCount = 0;
    int failCount  = 0;

    logic [3:0]         lastAim [PLAYERS];
    int                 ceRel   [PLAYERS];
    int                 afN     [PLAYERS];
    bit                 prevSrc [PLAYERS];
    logic [PLAYERS*4-1:0] expRun, expAim;
    logic [PLAYERS-1:0]   expTrig, expStart;
    logic                 expCoin;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Direction bits {D,R,L,U} from signed stick values, optional 45 degree turn, then SOCD.
    function automatic logic [3:0] modelDirs(input logic [15:0] stick, input logic [3:0] dig,
                                             input logic rot);
        int x, y;
        bit up, dn, lf, rt, u, d, l, r;
        logic [3:0] v;
        x  = int'($signed(stick[7:0]));
        y  = int'($signed(stick[15:8]));
        up = y < -DEADZONE;
        dn = y > DEADZONE;
        lf = x < -DEADZONE;
        rt = x > DEADZONE;
        if (rot) begin
            u = up && rt; d = dn && lf; l = up && lf; r = dn && rt;
        end else begin
            u = up; d = dn; l = lf; r = rt;
        end
        v = {d | dig[3], r | dig[2], l | dig[1], u | dig[0]};
        if (SOCD != 0) begin
            if (v[0] && v[3]) v = v & 4'b0110;
            if (v[1] && v[2]) v = v & 4'b1001;
        end
        return v;
    endfunction

    task automatic resetModel();
        for (int p = 0; p < PLAYERS; p++) begin
            lastAim[p] = 4'd0;
            ceRel[p]   = 0;
            afN[p]     = 0;
            prevSrc[p] = 1'b0;
        end
    endtask

    task automatic modelEdge();
        logic [31:0] j;
        logic [3:0]  aim;
        bit          src;
        expCoin = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            j = joy_digital[32*p +: 32];
            expRun[4*p +: 4] = modelDirs(analog_l[16*p +: 16], {j[2], j[0], j[1], j[3]}, cfg_rotate);
            aim = modelDirs(analog_r[16*p +: 16], {j[8], j[10], j[9], j[7]}, cfg_rotate);
            expStart[p] = j[5];
            expCoin = expCoin | j[6];
            if (aim != 4'd0) begin
                lastAim[p] = aim;
                ceRel[p]   = 0;
            end else if (lastAim[p] != 4'd0) begin
                if (ce) ceRel[p]++;
                if (ceRel[p] >= HOLD_TICKS) lastAim[p] = 4'd0;
            end
            expAim[4*p +: 4] = lastAim[p];
            src = cfg_aimfire ? (aim != 4'd0) : j[4];
            if (!src) begin
                expTrig[p] = 1'b0;
                afN[p] = 0;
            end else if (!prevSrc[p]) begin
                expTrig[p] = 1'b1;
                afN[p] = 0;
            end else begin
                if (ce) afN[p]++;
                expTrig[p] = cfg_autofire ? (((afN[p] / AF_PERIOD) % 2) == 0) : 1'b1;
            end
            prevSrc[p] = src;
        end
    endtask

    // One clock: inputs already set, sample 1 ns after the edge and compare with the model.
    task automatic applyStimulus();
        @(posedge clk_sys);
        #1;
        modelEdge();
        checkOutput("run",     32'(btn_run),     32'(expRun));
        checkOutput("aim",     32'(btn_aim),     32'(expAim));
        checkOutput("trigger", 32'(btn_trigger), 32'(expTrig));
        checkOutput("start",   32'(btn_start),   32'(expStart));
        checkOutput("coin",    32'(btn_coin),    32'(expCoin));
    endtask

    function automatic logic [7:0] pickAxis();
        case ($urandom_range(0, 7))
            0: return 8'h80;
            1: return 8'hEB;
            2: return 8'hEC;
            3: return 8'h00;
            4: return 8'h14;
            5: return 8'h15;
            6: return 8'h7F;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [31:0] pickJoy();
        logic [31:0] j;
        j = $urandom;
        for (int b = 0; b <= 10; b++) j[b] = ($urandom_range(0, 4) == 0);
        return j;
    endfunction

    int afPat [6] = '{1, 1, 0, 0, 0, 1};

    initial begin
        reset_n      = 1'b0;
        ce           = 1'b1;
        cfg_rotate   = 1'b1;
        cfg_aimfire  = 1'b1;
        cfg_autofire = 1'b1;
        joy_digital  = '1;
        analog_l     = {PLAYERS{16'h8080}};
        analog_r     = {PLAYERS{16'h8080}};
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("rst_run",  32'(btn_run),     32'd0);
        checkOutput("rst_aim",  32'(btn_aim),     32'd0);
        checkOutput("rst_trig", 32'(btn_trigger), 32'd0);
        checkOutput("rst_start",32'(btn_start),   32'd0);
        checkOutput("rst_coin", 32'(btn_coin),    32'd0);
        #3;
        reset_n = 1'b1;
        resetModel();
        applyStimulus();
        checkOutput("rst_socd_run0", 32'(btn_run[3:0]), 32'd0);

        ce = 1'b0; cfg_rotate = 1'b0; cfg_aimfire = 1'b0; cfg_autofire = 1'b0;
        joy_digital = '0; analog_l = '0; analog_r = '0;
        applyStimulus();

        analog_l[15:0] = {8'hEC, 8'h00};
        applyStimulus();
        checkOutput("dz_y_m20", 32'(btn_run[3:0]), 32'h0);
        analog_l[15:0] = {8'hEB, 8'h00};
        applyStimulus();
        checkOutput("dz_y_m21", 32'(btn_run[3:0]), 32'h1);
        analog_l[15:0] = {8'h00, 8'h80};
        applyStimulus();
        checkOutput("dz_x_m128", 32'(btn_run[3:0]), 32'h2);

        cfg_rotate = 1'b1;
        analog_l[15:0] = {8'hE2, 8'h1E};
        applyStimulus();
        checkOutput("rot_up_right", 32'(btn_run[3:0]), 32'h1);
        analog_l[15:0] = {8'h00, 8'h1E};
        applyStimulus();
        checkOutput("rot_cardinal", 32'(btn_run[3:0]), 32'h0);
        analog_l = '0;
        joy_digital[3] = 1'b1;
        applyStimulus();
        checkOutput("rot_digital", 32'(btn_run[3:0]), 32'h1);

        cfg_rotate = 1'b0;
        joy_digital = '0;
        joy_digital[10] = 1'b1;
        applyStimulus();
        checkOutput("hold_press", 32'(btn_aim[3:0]), 32'h4);
        joy_digital = '0;
        ce = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
            checkOutput($sformatf("hold_ce%0d", k), 32'(btn_aim[3:0]), (k < 4) ? 32'h4 : 32'h0);
        end
        ce = 1'b0;
        joy_digital[10] = 1'b1;
        applyStimulus();
        joy_digital = '0;
        ce = 1'b1;
        applyStimulus();
        ce = 1'b0;
        joy_digital[7] = 1'b1;
        applyStimulus();
        checkOutput("hold_replace", 32'(btn_aim[3:0]), 32'h1);
        joy_digital = '0;

        cfg_autofire = 1'b1;
        applyStimulus();
        joy_digital[4] = 1'b1;
        applyStimulus();
        checkOutput("af_rise", 32'(btn_trigger[0]), 32'd1);
        ce = 1'b1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            checkOutput($sformatf("af_ce%0d", k + 1), 32'(btn_trigger[0]), 32'(afPat[k]));
        end
        ce = 1'b0;
        joy_digital[4] = 1'b0;
        applyStimulus();
        checkOutput("af_release", 32'(btn_trigger[0]), 32'd0);
        cfg_autofire = 1'b0;

        cfg_aimfire = 1'b1;
        joy_digital[32+8] = 1'b1;
        joy_digital[32+6] = 1'b1;
        applyStimulus();
        checkOutput("aimfire_trig", 32'(btn_trigger), 32'h2);
        checkOutput("coin_p1", 32'(btn_coin), 32'd1);
        joy_digital = '0;
        cfg_aimfire = 1'b0;
        applyStimulus();

        for (int seg = 0; seg < 15; seg++) begin
            joy_digital  = '0;
            analog_l     = '0;
            analog_r     = '0;
            ce           = 1'b0;
            cfg_rotate   = 1'($urandom_range(0, 1));
            cfg_aimfire  = 1'($urandom_range(0, 1));
            cfg_autofire = 1'($urandom_range(0, 1));
            applyStimulus();
            for (int c = 0; c < 60; c++) begin
                ce = ($urandom_range(0, 2) == 0);
                for (int p = 0; p < PLAYERS; p++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        joy_digital[32*p +: 32] = pickJoy();
                        analog_l[16*p +: 16] = {pickAxis(), pickAxis()};
                        analog_r[16*p +: 16] = ($urandom_range(0, 1) == 0) ? 16'h0000
                                                                             : {pickAxis(), pickAxis()};
                    end
                end
                applyStimulus();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
